// File: rtl/axil_pkg.sv
// Shared types and helpers for the stream-to-AXI-lite writer.
package axil_pkg;

    // Write-channel sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } wr_state_t;

    // AXI-lite write response encoding as seen on the one-bit bresp.
    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // Width of a word-index counter for an n-word window (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte address of word idx; wraps naturally modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx,
                                              input logic [31:0] stride);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// One-entry stream holding register. Accepts a beat whenever empty and keeps
// it until the consumer pops it; reusable in front of any stream consumer.
module axis_hold_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_pop
);

    logic                  hold_valid_reg;
    logic [DATA_WIDTH-1:0] hold_data_reg;

    // Ready only when empty; held low during reset so nothing is taken then.
    assign s_ready = !hold_valid_reg && !areset;
    assign m_data  = hold_data_reg;
    assign m_valid = hold_valid_reg;

    // Load on an accepted beat, empty on pop (the two never coincide because
    // a load needs the entry empty and a pop needs it full).
    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (s_valid && s_ready) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= s_data;
        end else if (m_pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_axil_writer.sv
// Stream-to-register bridge: each stream beat becomes one AXI-lite write into
// a wrapping window of NUM_WORDS addresses starting at BASE_ADDR.
module axis_axil_writer
    import axil_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_STRIDE = 4,
    parameter int          NUM_WORDS   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [31:0]           awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic                  bresp,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int             IDX_W    = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    wr_state_t             state_reg, state_next;
    logic                  awvalid_reg, awvalid_next;
    logic                  wvalid_reg, wvalid_next;
    logic                  bready_reg, bready_next;
    logic [31:0]           awaddr_reg, awaddr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [7:0]            err_count_reg, err_count_next;

    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_pop;

    // Channel still waiting after this edge: valid now and no handshake now.
    logic aw_pend;
    logic w_pend;

    axis_hold_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .aclk    (aclk),
        .areset  (areset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (hold_data),
        .m_valid (hold_valid),
        .m_pop   (hold_pop)
    );

    assign aw_pend = awvalid_reg && !awready;
    assign w_pend  = wvalid_reg && !wready;

    // State and datapath registers; reset abandons any in-flight write.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= IDLE;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            awaddr_reg    <= '0;
            wdata_reg     <= '0;
            idx_reg       <= '0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            awaddr_reg    <= awaddr_next;
            wdata_reg     <= wdata_next;
            idx_reg       <= idx_next;
            err_count_reg <= err_count_next;
        end
    end

    // Next-state: issue when a beat is held, respond once both AW and W are
    // done (in either order), return to idle on the write response.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (hold_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!aw_pend && !w_pend) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath updates per state; values hold unless changed here.
    always_comb begin
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        awaddr_next    = awaddr_reg;
        wdata_next     = wdata_reg;
        idx_next       = idx_reg;
        err_count_next = err_count_reg;
        hold_pop       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hold_valid) begin
                    awaddr_next  = word_addr(BASE_ADDR, 32'(idx_reg), 32'(ADDR_STRIDE));
                    wdata_next   = hold_data;
                    awvalid_next = 1'b1;
                    wvalid_next  = 1'b1;
                    hold_pop     = 1'b1;
                end
            end
            WRITE: begin
                // Each channel drops on the edge after its own handshake.
                awvalid_next = aw_pend;
                wvalid_next  = w_pend;
                if (!aw_pend && !w_pend) begin
                    bready_next = 1'b1;
                end
            end
            RESP: begin
                if (bvalid) begin
                    bready_next = 1'b0;
                    idx_next    = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                    if (bresp == RESP_ERR && err_count_reg != 8'hFF) begin
                        err_count_next = err_count_reg + 8'd1;
                    end
                end
            end
            default: begin
                awvalid_next = 1'b0;
                wvalid_next  = 1'b0;
                bready_next  = 1'b0;
            end
        endcase
    end

    assign awaddr    = awaddr_reg;
    assign awvalid   = awvalid_reg;
    assign wdata     = wdata_reg;
    assign wvalid    = wvalid_reg;
    assign bready    = bready_reg;
    assign err_count = err_count_reg;
    assign busy      = hold_valid || (state_reg != IDLE);

endmodule
